// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, address stride and FSM state type for the memory arbiter.
package mem_arb_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] ADDR_STRIDE = 32'd4;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, VGA and shared-memory port signals; slave is the arbiter side.
interface mem_arbiter_if;
  import mem_arb_pkg::*;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic          vga_last;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata, vga_last,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata, vga_last,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_stats.sv
// mem_arb_stats: free-running wrap-around counters of CPU grants, VGA grants and VGA stall cycles.
module mem_arb_stats
  import mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_gnt,
  input  logic          vga_gnt,
  input  logic          stall_inc,
  output logic [DW-1:0] stat_cpu_gnt,
  output logic [DW-1:0] stat_vga_gnt,
  output logic [DW-1:0] stat_vga_stall
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cpu_gnt   <= '0;
      stat_vga_gnt   <= '0;
      stat_vga_stall <= '0;
    end else begin
      stat_cpu_gnt   <= stat_cpu_gnt + DW'(cpu_gnt);
      stat_vga_gnt   <= stat_vga_gnt + DW'(vga_gnt);
      stat_vga_stall <= stat_vga_stall + DW'(stall_inc);
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between CPU single accesses and VGA read bursts with anti-starvation.
// Define MEM_ARB_STATS_EN to add the stat_* grant/stall counter outputs.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int MAX_WAIT  = 8
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [DW-1:0] stat_cpu_gnt,
  output logic [DW-1:0] stat_vga_gnt,
  output logic [DW-1:0] stat_vga_stall
`endif
);
  localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(MAX_WAIT);
  arb_state_t    state, state_nx;
  logic [4:0]    beat, beat_nx;
  logic [AW-1:0] base;
  logic [7:0]    wait_cnt;
  logic          cpu_win, vga_win, burst_beat, vga_issue, last_issue, stall_inc;
  logic          cpu_rv_q, vga_rv_q, vga_last_q;
  // Issue decisions are gated by rst so every output drops the moment reset asserts.
  always_comb begin
    cpu_win    = rst && state == ARB_IDLE && bus.cpu_req && !(bus.vga_req && wait_cnt >= WAIT_MAX);
    vga_win    = rst && state == ARB_IDLE && bus.vga_req && !cpu_win;
    burst_beat = rst && state == ARB_BURST;
    vga_issue  = vga_win || burst_beat;
    last_issue = vga_win ? (LAST_BEAT == 5'd0) : (beat == LAST_BEAT);
    stall_inc  = rst && bus.vga_req && !vga_win && wait_cnt < WAIT_MAX;
    state_nx   = (vga_win && !last_issue) ? ARB_BURST : (burst_beat && last_issue) ? ARB_IDLE : state;
    beat_nx    = vga_win ? 5'd1 : burst_beat ? (last_issue ? 5'd0 : beat + 5'd1) : beat;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      beat       <= '0;
      base       <= '0;
      wait_cnt   <= '0;
      cpu_rv_q   <= 1'b0;
      vga_rv_q   <= 1'b0;
      vga_last_q <= 1'b0;
    end else begin
      state      <= state_nx;
      beat       <= beat_nx;
      if (vga_win) base <= bus.vga_addr;
      wait_cnt   <= vga_win ? 8'd0 : wait_cnt + 8'(stall_inc);
      cpu_rv_q   <= cpu_win && !bus.cpu_we;
      vga_rv_q   <= vga_issue;
      vga_last_q <= vga_issue && last_issue;
    end
  end
  assign bus.mem_en     = cpu_win || vga_issue;
  assign bus.mem_we     = cpu_win && bus.cpu_we;
  assign bus.mem_addr   = cpu_win ? bus.cpu_addr : vga_win ? bus.vga_addr :
                          burst_beat ? base + AW'(beat) * ADDR_STRIDE : '0;
  assign bus.mem_wdata  = cpu_win ? bus.cpu_wdata : '0;
  assign bus.cpu_gnt    = cpu_win;
  assign bus.vga_gnt    = vga_win;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.cpu_rdata  = cpu_rv_q ? bus.mem_rdata : '0;
  assign bus.vga_rvalid = vga_rv_q;
  assign bus.vga_rdata  = vga_rv_q ? bus.mem_rdata : '0;
  assign bus.vga_last   = vga_last_q;
`ifdef MEM_ARB_STATS_EN
  mem_arb_stats u_stats (
    .clk(clk),
    .rst(rst),
    .cpu_gnt(cpu_win),
    .vga_gnt(vga_win),
    .stall_inc(stall_inc),
    .stat_cpu_gnt(stat_cpu_gnt),
    .stat_vga_gnt(stat_vga_gnt),
    .stat_vga_stall(stat_vga_stall)
  );
`endif
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 4: VGA read beats per grant, legal 1..16.
REQ-002 Parameter MAX_WAIT, default 8: VGA stall cycles before VGA wins over CPU, legal 1..255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  CPU data access request, held with cpu_we/cpu_addr/cpu_wdata until cpu_gnt.
REQ-006 cpu_we  in  1  1=write, 0=read.
REQ-007 cpu_addr  in  32  byte address; cpu_wdata  in  32  write data.
REQ-008 cpu_gnt  out  1  one-cycle pulse in the cycle the CPU access is issued to memory.
REQ-009 cpu_rvalid  out  1; cpu_rdata  out  32  read return.
REQ-010 vga_req  in  1  VGA burst request, held with vga_addr until vga_gnt.
REQ-011 vga_addr  in  32  burst start byte address.
REQ-012 vga_gnt  out  1  one-cycle pulse in the first beat-issue cycle of a burst.
REQ-013 vga_rvalid  out  1; vga_rdata  out  32; vga_last  out  1  (final beat marker).
REQ-014 mem_en  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32  shared memory data port.
REQ-015 mem_rdata  in  32  valid the cycle after mem_en=1 and mem_we=0.

Function
REQ-016 FSM states IDLE (port free, arbitrating) and BURST (remaining VGA beats issuing).
REQ-017 In IDLE, priority: vga_req with wait_cnt>=MAX_WAIT; else cpu_req; else vga_req; else no access.
REQ-018 CPU win: same cycle mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_gnt=1; FSM stays IDLE.
REQ-019 CPU read: cpu_rvalid=1 and cpu_rdata=mem_rdata exactly one cycle after cpu_gnt; writes produce no rvalid.
REQ-020 VGA win: same cycle issue read at vga_addr, vga_gnt=1, latch vga_addr, beat counter=1; go BURST if BURST_LEN>1.
REQ-021 BURST: one read per cycle at latched addr+4*beat, no gaps, CPU blocked; after beat BURST_LEN-1 return to IDLE.
REQ-022 Address increment wraps modulo 2^32.
REQ-023 vga_rvalid=1 one cycle after each VGA beat issue; vga_last=1 with the BURST_LEN-th vga_rvalid only.
REQ-024 Cycle after final beat is IDLE and arbitrates normally (back-to-back grants allowed).
REQ-025 wait_cnt increments each cycle vga_req=1 and vga_gnt=0, saturates at MAX_WAIT, clears on vga_gnt.
REQ-026 Outside issue cycles mem_en=0, mem_we=0; mem_addr/mem_wdata drive 0.
REQ-027 cpu_rdata/vga_rdata drive 0 when the respective rvalid=0.

Reset
REQ-028 rst=0 forces IDLE, wait_cnt=0, beat counter=0, rvalid pipeline cleared, all outputs 0, immediately and asynchronously.
REQ-029 Reset mid-burst abandons the burst; no rvalid/last is emitted for beats issued before reset.

Configuration
REQ-030 Macro MEM_ARB_STATS_EN defined: add outputs stat_cpu_gnt (32), stat_vga_gnt (32), stat_vga_stall (32): counts of cpu_gnt, vga_gnt, and cycles wait_cnt increments; wrap at 2^32; cleared by rst.
REQ-031 Macro undefined: stat ports and counters absent; all other behaviour identical.

Structure
REQ-032 Package mem_arb_pkg holds the state enum (ARB_IDLE, ARB_BURST), ADDR_STRIDE=4, and data/address width constants (32).
REQ-033 Sub-module mem_arb_stats holds the three counters, instantiated only under MEM_ARB_STATS_EN.

Verification
REQ-034 cpu_req read at 0x100, vga_req=0 -> cpu_gnt and mem_en same cycle, cpu_rvalid next cycle with mem_rdata value.
REQ-035 vga_req at 0x2000, BURST_LEN=4 -> mem_addr 0x2000,0x2004,0x2008,0x200C on 4 consecutive cycles, vga_last on 4th rvalid.
REQ-036 cpu_req and vga_req both held continuously, MAX_WAIT=8 -> 8 CPU grants, then VGA burst, then CPU resumes.
REQ-037 vga_addr=0xFFFFFFF8, BURST_LEN=4 -> addresses 0xFFFFFFF8,0xFFFFFFFC,0x0,0x4.
REQ-038 rst=0 after beat 2 of a burst -> all outputs 0 immediately; after release no vga_rvalid until next grant.
REQ-039 With MEM_ARB_STATS_EN, scenario REQ-036 run for 24 cycles -> counters match observed gnt pulses and stall cycles.
